// File: rtl/pic_pkg.sv
// Shared constants, FSM encoding and helpers for the interrupt sequencer.
// Optional priority rotation is enabled with PIC_PRIORITY_ROTATE_EN.
package pic_pkg;

    localparam int unsigned PIC_NUM_IR = 8;
    localparam int unsigned IR_LEVEL_W = 3;

    localparam logic [IR_LEVEL_W-1:0] PIC_SPURIOUS_LEVEL = 3'd7;
    localparam logic [IR_LEVEL_W-1:0] PIC_LOWEST_DEFAULT = 3'd7;

    typedef logic [1:0] pic_state_t;

    localparam pic_state_t ST_IDLE   = 2'd0;
    localparam pic_state_t ST_ACK1   = 2'd1;
    localparam pic_state_t ST_WAIT2  = 2'd2;
    localparam pic_state_t ST_VECTOR = 2'd3;

    // One-hot decode of an IR level.
    function automatic logic [PIC_NUM_IR-1:0] level_onehot(input logic [IR_LEVEL_W-1:0] level);
        return PIC_NUM_IR'(1) << level;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Finds the highest-priority set bit of a vector under a rotating priority order
// where level (lowest_priority+1) mod 8 is highest.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [PIC_NUM_IR-1:0] vec,
    input  logic [IR_LEVEL_W-1:0] lowest_priority,
    output logic                  found_c,
    output logic [IR_LEVEL_W-1:0] level_c,
    output logic [IR_LEVEL_W-1:0] rank_c
);

    logic [IR_LEVEL_W-1:0]   highest_c;
    logic [2*PIC_NUM_IR-1:0] doubled_c;
    logic [PIC_NUM_IR-1:0]   rotated_c;

    assign highest_c = IR_LEVEL_W'(lowest_priority + 3'd1);
    assign doubled_c = {vec, vec};
    // Bit r of the rotated vector is the request at priority rank r.
    assign rotated_c = PIC_NUM_IR'(doubled_c >> highest_c);

    always_comb begin
        found_c = 1'b0;
        rank_c  = '0;
        for (int i = PIC_NUM_IR - 1; i >= 0; i--) begin
            if (rotated_c[i]) begin
                found_c = 1'b1;
                rank_c  = IR_LEVEL_W'(i);
            end
        end
    end

    assign level_c = IR_LEVEL_W'(rank_c + highest_c);

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// Priority resolution, INT/INTA handshake, ISR and EOI handling for an 8259-style PIC.
// Define PIC_PRIORITY_ROTATE_EN to enable rotate-on-EOI / rotate-on-AEOI priority.
module pic_interrupt_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned           NUM_IR         = PIC_NUM_IR,
    parameter logic [IR_LEVEL_W-1:0] SPURIOUS_LEVEL = PIC_SPURIOUS_LEVEL
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_IR-1:0]     irr,
    input  logic [NUM_IR-1:0]     imr,
    input  logic                  inta_n,
    input  logic [4:0]            vector_base,
    input  logic                  aeoi_mode,
    input  logic                  eoi_nonspecific,
    input  logic                  eoi_specific,
    input  logic [IR_LEVEL_W-1:0] eoi_level,
    input  logic                  rotate_on_eoi,
    output logic                  int_out,
    output logic                  freeze,
    output logic [NUM_IR-1:0]     clear_interrupt_request,
    output logic [NUM_IR-1:0]     isr,
    output logic [7:0]            data_out,
    output logic                  data_out_en
);

    pic_state_t            state, state_nxt;
    logic                  inta_prev;
    logic [IR_LEVEL_W-1:0] win_level, win_level_nxt;
    logic                  win_spurious, win_spurious_nxt;
    logic                  int_out_nxt, freeze_nxt, data_out_en_nxt;
    logic [NUM_IR-1:0]     clear_nxt, isr_nxt, ack_set, aeoi_clear;
    logic [7:0]            data_out_nxt;
    logic [IR_LEVEL_W-1:0] lowest_priority;

    logic                  req_found_c, isr_found_c, req_valid_c;
    logic [IR_LEVEL_W-1:0] req_level_c, req_rank_c, isr_level_c, isr_rank_c;
    logic                  inta_fall_c, inta_rise_c;
    logic [NUM_IR-1:0]     eoi_clear_c;

    pic_priority_resolver u_req_resolver (
        .vec             (irr & ~imr),
        .lowest_priority (lowest_priority),
        .found_c         (req_found_c),
        .level_c         (req_level_c),
        .rank_c          (req_rank_c)
    );

    pic_priority_resolver u_isr_resolver (
        .vec             (isr),
        .lowest_priority (lowest_priority),
        .found_c         (isr_found_c),
        .level_c         (isr_level_c),
        .rank_c          (isr_rank_c)
    );

    // Fully nested: a request must outrank everything already in service.
    assign req_valid_c = req_found_c && (!isr_found_c || (req_rank_c < isr_rank_c));
    assign inta_fall_c = inta_prev & ~inta_n;
    assign inta_rise_c = ~inta_prev & inta_n;

    // EOI looks at the pre-acknowledge ISR; specific EOI wins over non-specific.
    always_comb begin
        eoi_clear_c = '0;
        if (eoi_specific) begin
            eoi_clear_c = isr & level_onehot(eoi_level);
        end else if (eoi_nonspecific && isr_found_c) begin
            eoi_clear_c = level_onehot(isr_level_c);
        end
    end

    always_comb begin
        state_nxt        = state;
        int_out_nxt      = 1'b0;
        freeze_nxt       = freeze;
        clear_nxt        = '0;
        data_out_nxt     = data_out;
        data_out_en_nxt  = data_out_en;
        win_level_nxt    = win_level;
        win_spurious_nxt = win_spurious;
        ack_set          = '0;
        aeoi_clear       = '0;

        case (state)
            ST_IDLE: begin
                if (inta_fall_c) begin
                    state_nxt  = ST_ACK1;
                    freeze_nxt = 1'b1;
                    if (req_valid_c) begin
                        win_level_nxt    = req_level_c;
                        win_spurious_nxt = 1'b0;
                        ack_set          = level_onehot(req_level_c);
                        clear_nxt        = level_onehot(req_level_c);
                    end else begin
                        win_level_nxt    = SPURIOUS_LEVEL;
                        win_spurious_nxt = 1'b1;
                    end
                end else begin
                    int_out_nxt = req_valid_c;
                end
            end
            ST_ACK1: begin
                state_nxt = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (inta_fall_c) begin
                    state_nxt       = ST_VECTOR;
                    data_out_nxt    = {vector_base, win_level};
                    data_out_en_nxt = 1'b1;
                end
            end
            ST_VECTOR: begin
                if (inta_rise_c) begin
                    state_nxt       = ST_IDLE;
                    data_out_en_nxt = 1'b0;
                    freeze_nxt      = 1'b0;
                    if (aeoi_mode && !win_spurious) begin
                        aeoi_clear = level_onehot(win_level);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        isr_nxt = (isr & ~eoi_clear_c & ~aeoi_clear) | ack_set;
    end

`ifdef PIC_PRIORITY_ROTATE_EN
    logic [IR_LEVEL_W-1:0] lowest_priority_nxt;
    logic [IR_LEVEL_W-1:0] eoi_level_c;

    assign eoi_level_c = eoi_specific ? eoi_level : isr_level_c;

    always_comb begin
        lowest_priority_nxt = lowest_priority;
        if (rotate_on_eoi && (|eoi_clear_c)) begin
            lowest_priority_nxt = eoi_level_c;
        end
        if (rotate_on_eoi && (|aeoi_clear)) begin
            lowest_priority_nxt = win_level;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lowest_priority <= PIC_LOWEST_DEFAULT;
        end else begin
            lowest_priority <= lowest_priority_nxt;
        end
    end
`else
    logic unused_rotate_on_eoi;

    assign lowest_priority      = PIC_LOWEST_DEFAULT;
    assign unused_rotate_on_eoi = rotate_on_eoi;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= ST_IDLE;
            inta_prev               <= 1'b1;
            win_level               <= '0;
            win_spurious            <= 1'b0;
            int_out                 <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= '0;
            isr                     <= '0;
            data_out                <= '0;
            data_out_en             <= 1'b0;
        end else begin
            state                   <= state_nxt;
            inta_prev               <= inta_n;
            win_level               <= win_level_nxt;
            win_spurious            <= win_spurious_nxt;
            int_out                 <= int_out_nxt;
            freeze                  <= freeze_nxt;
            clear_interrupt_request <= clear_nxt;
            isr                     <= isr_nxt;
            data_out                <= data_out_nxt;
            data_out_en             <= data_out_en_nxt;
        end
    end

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed and randomized bench for pic_interrupt_sequencer against a priority-rule model.
module tb_pic_interrupt_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] irr, imr;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi_mode, eoi_nonspecific, eoi_specific, rotate_on_eoi;
    logic [2:0] eoi_level;
    logic       int_out, freeze, data_out_en;
    logic [7:0] clear_interrupt_request, isr, data_out;

`ifdef PIC_PRIORITY_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_isr;
    int         m_lowest;
    int         w;

    pic_interrupt_sequencer dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .irr                     (irr),
        .imr                     (imr),
        .inta_n                  (inta_n),
        .vector_base             (vector_base),
        .aeoi_mode               (aeoi_mode),
        .eoi_nonspecific         (eoi_nonspecific),
        .eoi_specific            (eoi_specific),
        .eoi_level               (eoi_level),
        .rotate_on_eoi           (rotate_on_eoi),
        .int_out                 (int_out),
        .freeze                  (freeze),
        .clear_interrupt_request (clear_interrupt_request),
        .isr                     (isr),
        .data_out                (data_out),
        .data_out_en             (data_out_en)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Position of a level in the current priority order (0 = highest).
    function automatic int rank_of(input int lvl, input int low);
        return (lvl + 7 - low) % 8;
    endfunction

    function automatic int pick(input logic [7:0] v, input int low);
        int best = -1;
        for (int l = 0; l < 8; l++) begin
            if (v[l] && (best < 0 || rank_of(l, low) < rank_of(best, low))) best = l;
        end
        return best;
    endfunction

    function automatic bit model_valid(input logic [7:0] rq, input logic [7:0] mk);
        int r = pick(rq & ~mk, m_lowest);
        int t = pick(m_isr, m_lowest);
        return (r >= 0) && (t < 0 || rank_of(r, m_lowest) < rank_of(t, m_lowest));
    endfunction

    task automatic model_eoi(input bit spec, input bit nonspec, input int lvl, input bit rot);
        int c = -1;
        if (spec) begin
            if (m_isr[lvl]) c = lvl;
        end else if (nonspec) begin
            c = pick(m_isr, m_lowest);
        end
        if (c >= 0) begin
            m_isr[c] = 1'b0;
            if (ROT && rot) m_lowest = c;
        end
    endtask

    task automatic pulse_eoi(input bit spec, input bit nonspec, input logic [2:0] lvl);
        eoi_specific    = spec;
        eoi_nonspecific = nonspec;
        eoi_level       = lvl;
        model_eoi(spec, nonspec, int'(lvl), rotate_on_eoi);
        tick();
        eoi_specific    = 1'b0;
        eoi_nonspecific = 1'b0;
        check("isr_after_eoi", isr, m_isr);
    endtask

    // Full two-pulse acknowledge, optionally with a specific EOI on the first edge.
    task automatic do_ack(input bit eoi_sp, input logic [2:0] eoi_lvl, output int win);
        bit         v;
        logic [7:0] oh;
        tick();
        tick();
        v = model_valid(irr, imr);
        check("int_out_idle", {7'b0, int_out}, {7'b0, v});
        win = v ? pick(irr & ~imr, m_lowest) : 7;
        oh  = v ? (8'h01 << win) : 8'h00;
        inta_n = 1'b0;
        if (eoi_sp) begin
            eoi_specific = 1'b1;
            eoi_level    = eoi_lvl;
            model_eoi(1'b1, 1'b0, int'(eoi_lvl), rotate_on_eoi);
        end
        m_isr = m_isr | oh;
        tick();
        eoi_specific = 1'b0;
        check("ack1_freeze", {7'b0, freeze}, 8'h01);
        check("ack1_int_out", {7'b0, int_out}, 8'h00);
        check("ack1_clear", clear_interrupt_request, oh);
        check("ack1_isr", isr, m_isr);
        tick();
        check("clear_one_cycle", clear_interrupt_request, 8'h00);
        inta_n = 1'b1;
        tick();
        tick();
        check("wait2_no_drive", {7'b0, data_out_en}, 8'h00);
        inta_n = 1'b0;
        tick();
        check("vector_en", {7'b0, data_out_en}, 8'h01);
        check("vector_byte", data_out, {vector_base, 3'(win)});
        tick();
        check("vector_hold", {7'b0, data_out_en}, 8'h01);
        inta_n = 1'b1;
        tick();
        if (aeoi_mode && v) begin
            m_isr[win] = 1'b0;
            if (ROT && rotate_on_eoi) m_lowest = win;
        end
        check("exit_en", {7'b0, data_out_en}, 8'h00);
        check("exit_freeze", {7'b0, freeze}, 8'h00);
        check("exit_isr", isr, m_isr);
    endtask

    initial begin
        reset_n = 1'b0; irr = 8'h00; imr = 8'h00; inta_n = 1'b1;
        vector_base = 5'h00; aeoi_mode = 1'b0; eoi_nonspecific = 1'b0;
        eoi_specific = 1'b0; eoi_level = 3'd0; rotate_on_eoi = 1'b0;
        m_isr = 8'h00; m_lowest = 7;
        #12;
        check("rst_int_out", {7'b0, int_out}, 8'h00);
        check("rst_freeze", {7'b0, freeze}, 8'h00);
        check("rst_clear", clear_interrupt_request, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_data", data_out, 8'h00);
        check("rst_data_en", {7'b0, data_out_en}, 8'h00);
        #10 reset_n = 1'b1;

        // Basic acknowledge: IR3 beats IR5.
        irr = 8'h28; vector_base = 5'h08;
        do_ack(1'b0, 3'd0, w);
        check("t1_isr", isr, 8'h08);
        check("t1_vector", data_out, 8'h43);
        pulse_eoi(1'b0, 1'b1, 3'd0);

        // Lower-priority request blocked by in-service IR2 until EOI.
        irr = 8'h04;
        do_ack(1'b0, 3'd0, w);
        irr = 8'h10;
        tick(); tick();
        check("t2_blocked", {7'b0, int_out}, 8'h00);
        pulse_eoi(1'b0, 1'b1, 3'd0);
        check("t2_isr_clear", isr, 8'h00);
        check("t2_int_lag", {7'b0, int_out}, 8'h00);
        tick();
        check("t2_int_after", {7'b0, int_out}, 8'h01);

        // Request withdrawn before the first INTA: spurious level 7.
        irr = 8'h01;
        tick(); tick();
        check("t3_int", {7'b0, int_out}, 8'h01);
        irr = 8'h00;
        do_ack(1'b0, 3'd0, w);
        check("t3_spurious", data_out, {vector_base, 3'd7});
        check("t3_isr", isr, 8'h00);

        // Specific EOI of level 5 coinciding with the ACK1 set of level 2.
        irr = 8'h20;
        do_ack(1'b0, 3'd0, w);
        check("t5_pre", isr, 8'h20);
        irr = 8'h04;
        do_ack(1'b1, 3'd5, w);
        check("t5_isr", isr, 8'h04);
        pulse_eoi(1'b0, 1'b1, 3'd0);

        // Reset while waiting for the second INTA.
        irr = 8'h02;
        tick(); tick();
        inta_n = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        check("rst2_freeze", {7'b0, freeze}, 8'h00);
        check("rst2_isr", isr, 8'h00);
        check("rst2_int", {7'b0, int_out}, 8'h00);
        check("rst2_clear", clear_interrupt_request, 8'h00);
        check("rst2_en", {7'b0, data_out_en}, 8'h00);
        m_isr = 8'h00; m_lowest = 7;
        inta_n = 1'b1;
        tick();
        reset_n = 1'b1;
        do_ack(1'b0, 3'd0, w);
        check("rst2_reack", isr, 8'h02);
        pulse_eoi(1'b0, 1'b1, 3'd0);

`ifdef PIC_PRIORITY_ROTATE_EN
        // AEOI with rotation: IR0 served first, then IR3 outranks IR0.
        irr = 8'h09; aeoi_mode = 1'b1; rotate_on_eoi = 1'b1;
        do_ack(1'b0, 3'd0, w);
        check("rot_first", {5'b0, data_out[2:0]}, 8'd0);
        check("rot_isr1", isr, 8'h00);
        do_ack(1'b0, 3'd0, w);
        check("rot_second", {5'b0, data_out[2:0]}, 8'd3);
        check("rot_isr2", isr, 8'h00);
        aeoi_mode = 1'b0; rotate_on_eoi = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            irr           = 8'($urandom);
            imr           = 8'($urandom & $urandom);
            vector_base   = 5'($urandom);
            aeoi_mode     = 1'($urandom);
            rotate_on_eoi = 1'($urandom);
            case ($urandom % 4)
                0: pulse_eoi(1'b0, 1'b1, 3'd0);
                1: pulse_eoi(1'b1, 1'b0, 3'($urandom));
                2: pulse_eoi(1'b1, 1'b1, 3'($urandom));
                default: ;
            endcase
            do_ack(1'b0, 3'd0, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pic_interrupt_sequencer.md
Name: pic_interrupt_sequencer

Overview:
Controls the interrupt request register.
- Resolves priority among pending, unmasked requests, raises the INT output, and runs the two-pulse INTA acknowledge handshake (8086 mode).
- Drives the request register's freeze and clear_interrupt_request inputs.
- Owns the in-service register (ISR) and EOI handling.
- Sits between the request register, the mask register/ICW-OCW decode, and the data bus buffer.

Parameters:
NUM_IR, 8, number of interrupt lines; only 8 is supported, fixed by the 3-bit level encoding
SPURIOUS_LEVEL, 3'd7, level reported when no request survives to the first INTA

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
irr  input  8  interrupt request register contents
imr  input  8  interrupt mask register (1 = masked)
inta_n  input  1  acknowledge strobe from the CPU, already synchronised to clock, active low
vector_base  input  5  ICW2 bits T7..T3
aeoi_mode  input  1  automatic EOI enabled (from ICW4)
eoi_nonspecific  input  1  one-cycle pulse: non-specific EOI command
eoi_specific  input  1  one-cycle pulse: specific EOI command
eoi_level  input  3  target level for specific EOI
rotate_on_eoi  input  1  qualifies EOI pulses with rotation (OCW2 R bit)
int_out  output  1  interrupt request to the CPU
freeze  output  1  freezes the request register during acknowledge
clear_interrupt_request  output  8  one-hot, one-cycle clear into the request register
isr  output  8  in-service register
data_out  output  8  vector byte
data_out_en  output  1  data bus drive enable

Behaviour:
- Reset: int_out=0, freeze=0, clear_interrupt_request=0, isr=0, data_out=0, data_out_en=0, lowest_priority=3'd7, state=IDLE. Reset mid-handshake aborts immediately; there is no partial ISR update.
- Priority order:
  - Highest priority is level (lowest_priority+1) mod 8, descending cyclically from there. Wrap-around is from 7 to 0.
  - req_win = highest-priority bit of irr & ~imr.
  - isr_top = highest-priority bit of isr.
  - A request is valid only if req_win is strictly higher priority than isr_top (fully nested); with isr=0, any request is valid.
- inta_n falling edge: detected as inta_n=0 while the previous sample was 1.
- FSM states and transitions:
  - IDLE: int_out = valid request, registered with 1-cycle latency from irr/imr/isr. On the 1st INTA falling edge → ACK1.
  - ACK1 (entry cycle):
    - freeze=1 from this cycle on.
    - Latch win_level = req_win, or SPURIOUS_LEVEL if no valid request.
    - For a non-spurious request: set isr[win_level] and pulse clear_interrupt_request[win_level] for exactly 1 cycle.
    - For a spurious request: no ISR set and no clear.
    - int_out=0.
    - Next state is WAIT2.
  - WAIT2: waits for the 2nd INTA falling edge → VECTOR.
  - VECTOR: data_out={vector_base,win_level} and data_out_en=1 while inta_n=0. On inta_n rising edge → IDLE. On exit: data_out_en=0 and freeze=0 in the same cycle; if aeoi_mode and not spurious, clear isr[win_level] and apply rotation per the optional feature.
- EOI handling:
  - Non-specific EOI clears isr_top; it is a no-op if isr=0.
  - Specific EOI clears isr[eoi_level]; it is a no-op if that bit is already 0.
  - EOI is accepted in any state.
  - If an EOI and the ACK1 ISR set fall in the same cycle, the EOI is evaluated against the pre-set isr and both take effect.
  - If both EOI pulses are asserted together, specific wins.
- Only the first two falling edges count. Extra INTA edges in VECTOR are ignored until return to IDLE.

Optional Feature:
PIC_PRIORITY_ROTATE_EN.
- Defined: an EOI with rotate_on_eoi=1 sets lowest_priority to the cleared level. An AEOI exit with rotate_on_eoi=1 sets lowest_priority=win_level.
- Undefined: rotate_on_eoi is ignored and lowest_priority stays 3'd7 (fixed IR0-highest order). The rotation logic is not synthesised.

Decomposition:
- Package pic_pkg holds:
  - FSM state enum (IDLE, ACK1, WAIT2, VECTOR)
  - IR_LEVEL_W=3
  - SPURIOUS_LEVEL default
- Sub-module pic_priority_resolver (combinational): rotates the 8-bit vector by lowest_priority and finds the first set bit. It is instantiated twice, once for irr&~imr and once for isr.

Test Plan:
- irr=8'h28, imr=0, isr=0, two INTA pulses → int_out=1; on the 1st edge isr=8'h08 and clear_interrupt_request=8'h08 for 1 cycle; on the 2nd pulse data_out=8'h43 with vector_base=5'h08.
- isr=8'h04, irr=8'h10 → int_out stays 0; after non-specific EOI, isr=0 and int_out=1 one cycle later.
- irr deasserts between INTA edges (irr=0 at ACK1) → spurious: isr unchanged, data_out={vector_base,3'd7}, no clear pulse.
- PIC_PRIORITY_ROTATE_EN, aeoi_mode=1, rotate_on_eoi=1: irr=8'h09, acknowledge IR0 → lowest_priority=0; the next acknowledge serves IR3, and isr=0 after each.
- Specific EOI level 5 in the same cycle as the ACK1 set of level 2 with isr=8'h20 → isr=8'h04 afterwards.
- reset_n low during WAIT2 → all outputs return to reset values immediately; a fresh request is acknowledged normally after release.
